halloween_effect_ctrl: RTL and testbench
========================================

# halloween_effect_ctrl

Command-consuming end of the decoration opcode stream. This block accepts the 4-bit opcodes that the channel sequencer produces, one per handshake, and executes them. It drives the decoration's actuator outputs: power state, LED colour, sound player, hand/jaw motion and the fog machine. Each effect is held for a parameterised number of cycles, and illegal or untimely commands are rejected with a flag.

## Interface
- SOUND_CYCLES, 8: cycles `sound_on` stays high per accepted sound opcode (1..255)
- MOVE_CYCLES, 4: cycles `wave_hands` / `move_jaw` stay high per trigger (1..255)
- FOG_CYCLES, 6: cycles `fog` stays high per trigger (1..255)
- FOG_COOLDOWN, 10: cycles after fog ends during which fog triggers are refused (0..255)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  opcode present
- opcode  in  4  command: [3:2] class (00 system, 01 colour, 10 sound, 11 movement), [1:0] index
- op_ready  out  1  block will accept opcode this cycle (combinational)
- powered  out  1  decoration on
- color_en  out  1  LEDs lit
- color  out  2  00 green, 01 purple, 10 orange
- sound_on  out  1  sound playing
- sound_sel  out  2  00 screaming, 01 cackling, 10 boo
- wave_hands  out  1  hand actuator
- move_jaw  out  1  jaw actuator
- fog  out  1  fog valve
- err_illegal  out  1  one-cycle pulse: undefined opcode accepted
- cmd_drop  out  1  one-cycle pulse: legal opcode accepted but discarded

## Operation
- Accept occurs when op_valid && op_ready at a rising edge. A transfer with op_valid=0 is ignored.
- op_ready = 0 only while sound_on=1 and opcode[3:2]=10; otherwise op_ready = 1. opcode may change while waiting.
- Legal opcodes: 0000 ON, 0001 RESET, 0100/0101/0110 colours, 1000/1001/1010 sounds, 1100 WAVEHANDS, 1101 MOVEJAW, 1110 FOG.
- Illegal opcodes: 0010, 0011, 0111, 1011, 1111. They are accepted with no state change and pulse err_illegal. Power state does not matter.
- ON: sets powered=1. If already on, no other effect.
- RESET: returns every output and timer to reset value, including powered=0. Pulses neither flag.
- Non-system legal opcode while powered=0: discarded, cmd_drop pulse.
- Colour: color := opcode[1:0], color_en := 1. Persists until RESET.
- Sound: sound_sel := opcode[1:0]; sound timer := SOUND_CYCLES. sound_on = (timer != 0). sound_sel holds its value after the sound ends.
- WAVEHANDS / MOVEJAW: each has its own 8-bit timer loaded with MOVE_CYCLES, output = (timer != 0). A retrigger while active reloads the timer, extending the motion.
- FOG state machine: FOG_IDLE -> (accept FOG) -> FOG_ON (timer=FOG_CYCLES) -> timer hits 0 -> FOG_COOL (timer=FOG_COOLDOWN) -> timer hits 0 -> FOG_IDLE.
  - If FOG_COOLDOWN=0, FOG_ON goes directly to FOG_IDLE.
  - fog = (state==FOG_ON).
  - FOG accepted in FOG_ON or FOG_COOL: discarded, cmd_drop pulse, no timer change.
- Timers decrement by 1 per cycle when non-zero. If a load and a decrement coincide, the load wins.

## Timing
- Reset values: powered=0, color_en=0, color=00, sound_on=0, sound_sel=00, wave_hands=0, move_jaw=0, fog=0, err_illegal=0, cmd_drop=0. All timers are 0 and the fog state is FOG_IDLE.
- All outputs except op_ready are registered. An opcode accepted at edge k is reflected in the outputs immediately after edge k (latency 1).
- err_illegal and cmd_drop are high for exactly the one cycle after the accepting edge.
- An effect with N cycles is high for exactly N clock cycles, starting after the accepting edge.
- Back-to-back sounds: the second is accepted at the first edge where sound_on=0, which leaves one idle cycle between sounds.
- Fog re-arms exactly FOG_CYCLES+FOG_COOLDOWN cycles after the accepting edge.
- rst mid-effect: all outputs drop asynchronously, with no glitch pulse on the flags.
- At most one opcode is accepted per cycle. Independent timers run concurrently.

## Test plan
- Reset, then ON, then 0101 -> powered=1 one cycle after ON, color_en=1 and color=01 one cycle after 0101.
- While powered=0, send 1000 -> cmd_drop pulses once and sound_on stays 0. Send 0011 -> err_illegal pulses once.
- Powered, 1010 with op_valid held and a second 1001 queued:
  - sound_on is high for 8 cycles with sound_sel=10.
  - op_ready is 0 for the second opcode during those 8 cycles.
  - The second opcode is accepted one cycle after sound_on falls, then sound_sel=01.
- Powered, 1100, then 1100 again 2 cycles later -> wave_hands is high for 6 consecutive cycles in total.
- Powered, 1110, then 1110 every cycle -> fog high for 6 cycles, a cmd_drop on each refused cycle through 16 cycles, and the next 1110 accepted at cycle 16.
- Powered with fog, sound and jaw active, send 0001 (RESET) -> all outputs return to reset values the next cycle. Separately, assert rst asynchronously mid-sound -> same result without waiting for a clock edge.

Source files
------------

// File: rtl/halloween_effect_ctrl_if.sv
// Opcode handshake between the channel sequencer (master) and the effect
// controller (slave).
//   op_valid : master -> slave, opcode present
//   opcode   : master -> slave, 4-bit command {class[1:0], index[1:0]}
//   op_ready : slave -> master, opcode will be accepted this cycle
interface halloween_effect_ctrl_if;
  logic       op_valid;
  logic [3:0] opcode;
  logic       op_ready;

  modport master (
    output op_valid,
    output opcode,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  opcode,
    output op_ready
  );
endinterface

// File: rtl/halloween_effect_ctrl.sv
// Decoration effect controller: executes opcodes from the sequencer and
// drives power, LED colour, sound, hand/jaw motion and fog actuators.
// Each timed effect holds for a parameterised number of cycles; illegal
// opcodes pulse err_illegal, legal-but-unusable ones pulse cmd_drop.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   cmd          : opcode handshake (slave side of halloween_effect_ctrl_if)
//   powered      : decoration on
//   color_en     : LEDs lit
//   color        : 00 green, 01 purple, 10 orange
//   sound_on     : sound playing
//   sound_sel    : 00 screaming, 01 cackling, 10 boo
//   wave_hands   : hand actuator
//   move_jaw     : jaw actuator
//   fog          : fog valve
//   err_illegal  : one-cycle pulse, undefined opcode accepted
//   cmd_drop     : one-cycle pulse, legal opcode accepted but discarded
module halloween_effect_ctrl #(
  parameter int unsigned SOUND_CYCLES = 8,
  parameter int unsigned MOVE_CYCLES  = 4,
  parameter int unsigned FOG_CYCLES   = 6,
  parameter int unsigned FOG_COOLDOWN = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  halloween_effect_ctrl_if.slave  cmd,
  output logic                    powered,
  output logic                    color_en,
  output logic [1:0]              color,
  output logic                    sound_on,
  output logic [1:0]              sound_sel,
  output logic                    wave_hands,
  output logic                    move_jaw,
  output logic                    fog,
  output logic                    err_illegal,
  output logic                    cmd_drop
);

  typedef enum logic [1:0] {
    FOG_IDLE,
    FOG_ON,
    FOG_COOL
  } fog_state_e;

  fog_state_e fog_state;
  logic [7:0] sound_tmr;
  logic [7:0] wave_tmr;
  logic [7:0] jaw_tmr;
  logic [7:0] fog_tmr;

  logic [1:0] op_class;
  logic [1:0] op_idx;
  logic       accept;
  logic       is_illegal;
  logic       fog_rearm;

  assign op_class     = cmd.opcode[3:2];
  assign op_idx       = cmd.opcode[1:0];
  assign cmd.op_ready = !(sound_on && (op_class == 2'b10));
  assign accept       = cmd.op_valid && cmd.op_ready;

  always_comb begin
    is_illegal = 1'b0;
    case (cmd.opcode)
      4'b0010, 4'b0011, 4'b0111, 4'b1011, 4'b1111: is_illegal = 1'b1;
      default:                                     is_illegal = 1'b0;
    endcase
  end

  // A fog trigger landing on the edge where the last busy timer expires is
  // taken (load beats decrement), so fog re-arms exactly
  // FOG_CYCLES + FOG_COOLDOWN cycles after the accepting edge.
  assign fog_rearm = (fog_state == FOG_IDLE) ||
                     ((fog_state == FOG_COOL) && (fog_tmr == 8'd1)) ||
                     ((fog_state == FOG_ON) && (fog_tmr == 8'd1) &&
                      (FOG_COOLDOWN == 0));

  // Effect outputs track (next timer != 0) so they are true flops that
  // always equal (timer != 0) of the registered timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      powered     <= 1'b0;
      color_en    <= 1'b0;
      color       <= '0;
      sound_on    <= 1'b0;
      sound_sel   <= '0;
      wave_hands  <= 1'b0;
      move_jaw    <= 1'b0;
      fog         <= 1'b0;
      err_illegal <= 1'b0;
      cmd_drop    <= 1'b0;
      sound_tmr   <= '0;
      wave_tmr    <= '0;
      jaw_tmr     <= '0;
      fog_tmr     <= '0;
      fog_state   <= FOG_IDLE;
    end else begin
      err_illegal <= 1'b0;
      cmd_drop    <= 1'b0;

      if (sound_tmr != '0) begin
        sound_tmr <= sound_tmr - 8'd1;
        sound_on  <= (sound_tmr != 8'd1);
      end
      if (wave_tmr != '0) begin
        wave_tmr   <= wave_tmr - 8'd1;
        wave_hands <= (wave_tmr != 8'd1);
      end
      if (jaw_tmr != '0) begin
        jaw_tmr  <= jaw_tmr - 8'd1;
        move_jaw <= (jaw_tmr != 8'd1);
      end

      case (fog_state)
        FOG_ON: begin
          if (fog_tmr == 8'd1) begin
            fog <= 1'b0;
            if (FOG_COOLDOWN == 0) begin
              fog_state <= FOG_IDLE;
              fog_tmr   <= '0;
            end else begin
              fog_state <= FOG_COOL;
              fog_tmr   <= 8'(FOG_COOLDOWN);
            end
          end else begin
            fog_tmr <= fog_tmr - 8'd1;
          end
        end
        FOG_COOL: begin
          if (fog_tmr == 8'd1) begin
            fog_state <= FOG_IDLE;
            fog_tmr   <= '0;
          end else begin
            fog_tmr <= fog_tmr - 8'd1;
          end
        end
        default: ;
      endcase

      // Command execution comes last so loads override the decrements above.
      if (accept) begin
        if (is_illegal) begin
          err_illegal <= 1'b1;
        end else if (op_class == 2'b00) begin
          if (op_idx == 2'b00) begin
            powered <= 1'b1;
          end else begin
            powered    <= 1'b0;
            color_en   <= 1'b0;
            color      <= '0;
            sound_on   <= 1'b0;
            sound_sel  <= '0;
            wave_hands <= 1'b0;
            move_jaw   <= 1'b0;
            fog        <= 1'b0;
            sound_tmr  <= '0;
            wave_tmr   <= '0;
            jaw_tmr    <= '0;
            fog_tmr    <= '0;
            fog_state  <= FOG_IDLE;
          end
        end else if (!powered) begin
          cmd_drop <= 1'b1;
        end else begin
          case (op_class)
            2'b01: begin
              color_en <= 1'b1;
              color    <= op_idx;
            end
            2'b10: begin
              sound_sel <= op_idx;
              sound_tmr <= 8'(SOUND_CYCLES);
              sound_on  <= 1'b1;
            end
            default: begin
              case (op_idx)
                2'b00: begin
                  wave_tmr   <= 8'(MOVE_CYCLES);
                  wave_hands <= 1'b1;
                end
                2'b01: begin
                  jaw_tmr  <= 8'(MOVE_CYCLES);
                  move_jaw <= 1'b1;
                end
                default: begin
                  if (fog_rearm) begin
                    fog_state <= FOG_ON;
                    fog_tmr   <= 8'(FOG_CYCLES);
                    fog       <= 1'b1;
                  end else begin
                    cmd_drop <= 1'b1;
                  end
                end
              endcase
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_halloween_effect_ctrl.sv
// Scoreboard bench for halloween_effect_ctrl. The driver issues directed
// opcodes and queues cycle-tagged expected output snapshots (mask + value);
// the monitor samples on the falling edge and checks every entry due.
module tb_halloween_effect_ctrl;

  // Snapshot bit layout
  localparam logic [12:0] POW = 13'h1000;
  localparam logic [12:0] CEN = 13'h0800;
  localparam logic [12:0] COL = 13'h0600;
  localparam logic [12:0] SON = 13'h0100;
  localparam logic [12:0] SEL = 13'h00C0;
  localparam logic [12:0] WAV = 13'h0020;
  localparam logic [12:0] JAW = 13'h0010;
  localparam logic [12:0] FOG = 13'h0008;
  localparam logic [12:0] ERR = 13'h0004;
  localparam logic [12:0] DRP = 13'h0002;
  localparam logic [12:0] RDY = 13'h0001;
  localparam logic [12:0] ALL = 13'h1FFF;
  localparam logic [12:0] RST_V = 13'h0001;

  localparam logic [12:0] COL_PURPLE = 13'h0200;
  localparam logic [12:0] COL_ORANGE = 13'h0400;
  localparam logic [12:0] SEL_CACKLE = 13'h0040;
  localparam logic [12:0] SEL_BOO    = 13'h0080;

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] mask;
    logic [12:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic powered, color_en, sound_on, wave_hands, move_jaw, fog;
  logic err_illegal, cmd_drop;
  logic [1:0] color, sound_sel;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];

  halloween_effect_ctrl_if ifc ();

  halloween_effect_ctrl #(
    .SOUND_CYCLES (8),
    .MOVE_CYCLES  (4),
    .FOG_CYCLES   (6),
    .FOG_COOLDOWN (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (ifc.slave),
    .powered     (powered),
    .color_en    (color_en),
    .color       (color),
    .sound_on    (sound_on),
    .sound_sel   (sound_sel),
    .wave_hands  (wave_hands),
    .move_jaw    (move_jaw),
    .fog         (fog),
    .err_illegal (err_illegal),
    .cmd_drop    (cmd_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input string n,
                          input logic [12:0] m, input logic [12:0] v);
    exp_t e;
    e.cyc = c; e.name = n; e.mask = m; e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] op);
    ifc.opcode   = op;
    ifc.op_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.op_valid = 1'b0;
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    logic [12:0] act;
    exp_t e;
    act = {powered, color_en, color, sound_on, sound_sel, wave_hands,
           move_jaw, fog, err_illegal, cmd_drop, ifc.op_ready};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total = total + 1;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        bad = bad + 1;
        $display("FAIL %s cyc=%0d got=%013b want=%013b mask=%013b",
                 e.name, cyc, act & e.mask, e.val & e.mask, e.mask);
      end
    end
  end

  initial begin
    int a;
    rst = 1'b1;
    ifc.op_valid = 1'b0;
    ifc.opcode   = '0;
    tick(3);
    rst = 1'b0;
    push_exp(cyc, "reset_state", ALL, RST_V);
    tick(2);

    // Unpowered: legal effect dropped, illegal flagged
    send(4'b1000); a = cyc;
    push_exp(a,     "drop_unpowered",  DRP | SON, DRP);
    push_exp(a + 1, "drop_one_cycle",  DRP | SON, '0);
    send(4'b0011); a = cyc;
    push_exp(a,     "illegal_unpowered", ERR | DRP | POW, ERR);
    push_exp(a + 1, "illegal_one_cycle", ERR, '0);

    // Power and colour
    send(4'b0000);
    push_exp(cyc, "power_on", POW | CEN, POW);
    send(4'b0101);
    push_exp(cyc, "colour_purple", POW | CEN | COL, POW | CEN | COL_PURPLE);
    send(4'b0111);
    push_exp(cyc, "illegal_powered", ERR | DRP | POW | CEN | COL,
             ERR | POW | CEN | COL_PURPLE);
    send(4'b0110);
    push_exp(cyc, "colour_orange", CEN | COL | ERR, CEN | COL_ORANGE);
    tick(2);

    // Back-to-back sounds: second waits while the first plays
    ifc.opcode   = 4'b1010;
    ifc.op_valid = 1'b1;
    tick(1); a = cyc;
    ifc.opcode = 4'b1001;
    for (int j = 0; j < 8; j++)
      push_exp(a + j, "sound_first", SON | SEL | RDY, SON | SEL_BOO);
    push_exp(a + 8, "sound_gap", SON | RDY | SEL, RDY | SEL_BOO);
    push_exp(a + 9, "sound_second", SON | SEL, SON | SEL_CACKLE);
    tick(9);
    ifc.op_valid = 1'b0;
    push_exp(a + 16, "sound_second_tail", SON, SON);
    push_exp(a + 17, "sound_end_sel_held", SON | SEL, SEL_CACKLE);
    tick(10);

    // Hand wave retriggered two cycles in
    send(4'b1100); a = cyc;
    for (int j = 0; j < 6; j++)
      push_exp(a + j, "wave_extended", WAV | JAW, WAV);
    push_exp(a + 6, "wave_end", WAV, '0);
    tick(1);
    send(4'b1100);
    tick(6);

    // Fog requested every cycle: on, cooldown refusals, re-arm
    ifc.opcode   = 4'b1110;
    ifc.op_valid = 1'b1;
    tick(1); a = cyc;
    for (int j = 0; j <= 16; j++)
      push_exp(a + j, "fog_hold", FOG | DRP,
               ((j < 6 || j == 16) ? FOG : 13'h0) |
               ((j >= 1 && j <= 15) ? DRP : 13'h0));
    tick(16);
    ifc.op_valid = 1'b0;
    push_exp(a + 17, "fog_retrig",      FOG | DRP, FOG);
    push_exp(a + 21, "fog_retrig_tail", FOG, FOG);
    push_exp(a + 22, "fog_retrig_end",  FOG, '0);
    tick(30);

    // RESET opcode with several effects running
    send(4'b1110);
    send(4'b1000);
    send(4'b1101); a = cyc;
    push_exp(a, "all_active", POW | SON | JAW | FOG, POW | SON | JAW | FOG);
    send(4'b0001);
    push_exp(cyc,     "reset_opcode",      ALL, RST_V);
    push_exp(cyc + 1, "reset_opcode_hold", ALL, RST_V);
    tick(2);

    // Asynchronous rst mid-sound
    send(4'b0000);
    send(4'b1001); a = cyc;
    push_exp(a + 1, "sound_before_rst", POW | SON | SEL, POW | SON | SEL_CACKLE);
    tick(2);
    push_exp(cyc, "async_rst", ALL, RST_V);
    rst = 1'b1;
    tick(2);
    push_exp(cyc, "rst_held", ALL, RST_V);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
      total = total + sb.size();
      bad   = bad + sb.size();
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
